// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//   Writeback stage for the simplified MIPS pipeline. Formats load data
//   (LB/LBU/LH/LHU/LW) as results arrive from MEM/WB. Queues register writes
//   in a DEPTH-entry FIFO, so a busy register-file port back-pressures MEM
//   rather than dropping writes. It also offers a youngest-match forwarding
//   lookup over the pending entries.
//
// Ports
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   mem_wb_valid       MEM offers a result this cycle
//   mem_wb_ready       stage can accept the offered result (count < DEPTH)
//   mem_wb_regdest     destination register
//   mem_wb_writereg    result writes the register file
//   mem_wb_memtoreg    1: wbvalue is a raw memory word, 0: ALU result
//   mem_wb_loadtype    000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU
//   mem_wb_byteaddr    address[1:0] of the load
//   mem_wb_wbvalue     ALU result or raw memory word
//   wb_reg_en          head entry valid, write requested
//   wb_reg_addr        head destination register (0 when empty)
//   wb_reg_data        head formatted data (0 when empty)
//   wb_reg_ready       register-file port accepts the write this cycle
//   fwd_addr           forwarding query address
//   fwd_hit            a pending entry targets fwd_addr
//   fwd_data           data of the youngest matching entry (0 if no hit)
//   wb_count           number of occupied entries
// -----------------------------------------------------------------------------
module writeback_queue #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4,
    parameter bit ZERO_DROP  = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      mem_wb_valid,
    output logic                      mem_wb_ready,
    input  logic [REG_ADDR_W-1:0]     mem_wb_regdest,
    input  logic                      mem_wb_writereg,
    input  logic                      mem_wb_memtoreg,
    input  logic [2:0]                mem_wb_loadtype,
    input  logic [1:0]                mem_wb_byteaddr,
    input  logic [31:0]               mem_wb_wbvalue,
    output logic                      wb_reg_en,
    output logic [REG_ADDR_W-1:0]     wb_reg_addr,
    output logic [31:0]               wb_reg_data,
    input  logic                      wb_reg_ready,
    input  logic [REG_ADDR_W-1:0]     fwd_addr,
    output logic                      fwd_hit,
    output logic [31:0]               fwd_data,
    output logic [$clog2(DEPTH):0]    wb_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } loadtype_e;

    logic [REG_ADDR_W-1:0] r_addr  [DEPTH];
    logic [31:0]           r_data  [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_fmt;
    logic [PTR_W-1:0]      w_fwd_idx;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign mem_wb_ready = (r_count < CNT_W'(DEPTH));
    assign w_accept     = mem_wb_valid & mem_wb_ready;
    // Beats that write nothing (or write r0) are consumed without enqueueing.
    assign w_push       = w_accept & mem_wb_writereg &
                          !(ZERO_DROP && (mem_wb_regdest == '0));
    assign wb_reg_en    = (r_count != '0);
    assign w_pop        = wb_reg_en & wb_reg_ready;
    assign wb_reg_addr  = wb_reg_en ? r_addr[r_rptr] : '0;
    assign wb_reg_data  = wb_reg_en ? r_data[r_rptr] : '0;
    assign wb_count     = r_count;

    // ------------------------------------------------------------------
    // Load formatting (little-endian lanes)
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = '0;
        case (mem_wb_byteaddr)
            2'd0:    w_byte = mem_wb_wbvalue[7:0];
            2'd1:    w_byte = mem_wb_wbvalue[15:8];
            2'd2:    w_byte = mem_wb_wbvalue[23:16];
            default: w_byte = mem_wb_wbvalue[31:24];
        endcase
        // Halfword lane ignores byteaddr[0].
        w_half = mem_wb_byteaddr[1] ? mem_wb_wbvalue[31:16] : mem_wb_wbvalue[15:0];

        w_fmt = mem_wb_wbvalue;
        if (mem_wb_memtoreg) begin
            case (loadtype_e'(mem_wb_loadtype))
                LT_LB:   w_fmt = {{24{w_byte[7]}}, w_byte};
                LT_LBU:  w_fmt = {24'h0, w_byte};
                LT_LH:   w_fmt = {{16{w_half[15]}}, w_half};
                LT_LHU:  w_fmt = {16'h0, w_half};
                default: w_fmt = mem_wb_wbvalue;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            // Pop and push never target the same slot: that would need
            // count==0 with a pop, or count==DEPTH with a push.
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + 1'b1;
            end
            if (w_push) begin
                r_addr[r_wptr]  <= mem_wb_regdest;
                r_data[r_wptr]  <= w_fmt;
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: walk from oldest to youngest so the last match wins.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        w_fwd_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_fwd_idx = r_rptr + PTR_W'(i);
            if (r_valid[w_fwd_idx] && (r_addr[w_fwd_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[w_fwd_idx];
            end
        end
        if (ZERO_DROP && (fwd_addr == '0)) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

    localparam int AW = 5;
    localparam int DP = 4;

    logic          clock;
    logic          reset_n;
    logic          mem_wb_valid;
    logic          mem_wb_ready;
    logic [AW-1:0] mem_wb_regdest;
    logic          mem_wb_writereg;
    logic          mem_wb_memtoreg;
    logic [2:0]    mem_wb_loadtype;
    logic [1:0]    mem_wb_byteaddr;
    logic [31:0]   mem_wb_wbvalue;
    logic          wb_reg_en;
    logic [AW-1:0] wb_reg_addr;
    logic [31:0]   wb_reg_data;
    logic          wb_reg_ready;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [2:0]    wb_count;

    writeback_queue #(
        .REG_ADDR_W(AW),
        .DEPTH     (DP),
        .ZERO_DROP (1'b1)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_wb_valid   (mem_wb_valid),
        .mem_wb_ready   (mem_wb_ready),
        .mem_wb_regdest (mem_wb_regdest),
        .mem_wb_writereg(mem_wb_writereg),
        .mem_wb_memtoreg(mem_wb_memtoreg),
        .mem_wb_loadtype(mem_wb_loadtype),
        .mem_wb_byteaddr(mem_wb_byteaddr),
        .mem_wb_wbvalue (mem_wb_wbvalue),
        .wb_reg_en      (wb_reg_en),
        .wb_reg_addr    (wb_reg_addr),
        .wb_reg_data    (wb_reg_data),
        .wb_reg_ready   (wb_reg_ready),
        .fwd_addr       (fwd_addr),
        .fwd_hit        (fwd_hit),
        .fwd_data       (fwd_data),
        .wb_count       (wb_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        mem_wb_valid    = 1'b0;
        mem_wb_regdest  = '0;
        mem_wb_writereg = 1'b0;
        mem_wb_memtoreg = 1'b0;
        mem_wb_loadtype = 3'b000;
        mem_wb_byteaddr = 2'b00;
        mem_wb_wbvalue  = '0;
        wb_reg_ready    = 1'b0;
        fwd_addr        = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #7;
        reset_n = 1'b1;
        step();
    endtask

    task automatic push(input logic [AW-1:0] rd, input logic [31:0] v);
        mem_wb_valid    = 1'b1;
        mem_wb_writereg = 1'b1;
        mem_wb_memtoreg = 1'b0;
        mem_wb_regdest  = rd;
        mem_wb_wbvalue  = v;
    endtask

    // Reference formatter, built from plain shifts and arithmetic.
    function automatic logic [31:0] mfmt(input logic m2r, input logic [2:0] lt,
                                         input logic [1:0] ba, input logic [31:0] v);
        int unsigned b;
        int unsigned h;
        int unsigned sh;
        b  = (v >> (8 * ba)) & 32'd255;
        sh = ba[1] ? 16 : 0;
        h  = (v >> sh) & 32'd65535;
        if (!m2r) return v;
        case (lt)
            3'd1: return (b >= 128) ? (b + 32'hFFFFFF00) : b;
            3'd2: return b;
            3'd3: return (h >= 32768) ? (h + 32'hFFFF0000) : h;
            3'd4: return h;
            default: return v;
        endcase
    endfunction

    typedef struct {
        logic        m2r;
        logic [2:0]  lt;
        logic [1:0]  ba;
        logic [31:0] v;
        logic [31:0] exp;
    } fmt_vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } ent_t;

    fmt_vec_t vecs[12];
    ent_t     mq[$];

    initial begin
        logic [AW-1:0] exp_seq[5];
        logic          e_ready, e_en, e_hit;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_data, e_fdata;

        vecs[0]  = '{1'b1, 3'b001, 2'd1, 32'h80FF7F01, 32'h0000007F};
        vecs[1]  = '{1'b1, 3'b010, 2'd1, 32'h80FF7F01, 32'h0000007F};
        vecs[2]  = '{1'b1, 3'b001, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
        vecs[3]  = '{1'b1, 3'b011, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[4]  = '{1'b1, 3'b100, 2'd2, 32'h80FF7F01, 32'h000080FF};
        vecs[5]  = '{1'b1, 3'b010, 2'd3, 32'h80FF7F01, 32'h00000080};
        vecs[6]  = '{1'b1, 3'b011, 2'd3, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[7]  = '{1'b1, 3'b011, 2'd0, 32'h80FF7F01, 32'h00007F01};
        vecs[8]  = '{1'b1, 3'b001, 2'd0, 32'h80FF7F01, 32'h00000001};
        vecs[9]  = '{1'b1, 3'b000, 2'd1, 32'h80FF7F01, 32'h80FF7F01};
        vecs[10] = '{1'b1, 3'b111, 2'd2, 32'h80FF7F01, 32'h80FF7F01};
        vecs[11] = '{1'b0, 3'b001, 2'd3, 32'h80FF7F01, 32'h80FF7F01};

        idle_inputs();
        reset_n = 1'b0;
        #3;
        // Reset state
        chk("rst_ready", mem_wb_ready, 1);
        chk("rst_en",    wb_reg_en,    0);
        chk("rst_addr",  wb_reg_addr,  0);
        chk("rst_data",  wb_reg_data,  0);
        chk("rst_hit",   fwd_hit,      0);
        chk("rst_fdata", fwd_data,     0);
        chk("rst_count", wb_count,     0);
        #4;
        reset_n = 1'b1;
        step();

        // ALU write r3, port ready
        wb_reg_ready = 1'b1;
        push(5'd3, 32'h12345678);
        step();
        mem_wb_valid = 1'b0;
        chk("alu_en",    wb_reg_en,   1);
        chk("alu_addr",  wb_reg_addr, 3);
        chk("alu_data",  wb_reg_data, 32'h12345678);
        chk("alu_count", wb_count,    1);
        step();
        chk("alu_popped", wb_count, 0);

        // Formatting table
        foreach (vecs[i]) begin
            mem_wb_valid    = 1'b1;
            mem_wb_writereg = 1'b1;
            mem_wb_regdest  = 5'd9;
            mem_wb_memtoreg = vecs[i].m2r;
            mem_wb_loadtype = vecs[i].lt;
            mem_wb_byteaddr = vecs[i].ba;
            mem_wb_wbvalue  = vecs[i].v;
            step();
            mem_wb_valid = 1'b0;
            chk($sformatf("fmt_%0d", i), wb_reg_data, vecs[i].exp);
            step();
        end
        chk("fmt_empty", wb_count, 0);

        // Back-pressure: five pushes with the port stalled
        wb_reg_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(AW'(k + 1), 32'h100 + 32'(k));
            #1;
            chk($sformatf("bp_ready_%0d", k), mem_wb_ready, (k < 4) ? 1 : 0);
            if (k < 4) step();
        end
        chk("bp_count", wb_count, 4);
        exp_seq = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
        wb_reg_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk($sformatf("bp_order_%0d", j), wb_reg_addr, exp_seq[j]);
            chk($sformatf("bp_data_%0d", j), wb_reg_data, 32'h100 + 32'(exp_seq[j]) - 1);
            step();
            if (j == 1) mem_wb_valid = 1'b0;
        end
        chk("bp_drained", wb_count, 0);
        chk("bp_en0", wb_reg_en, 0);

        // Forwarding, youngest wins
        wb_reg_ready = 1'b0;
        push(5'd7, 32'hA);
        step();
        push(5'd7, 32'hB);
        step();
        mem_wb_valid = 1'b0;
        fwd_addr     = 5'd7;
        #1;
        chk("fwd_hit2",  fwd_hit,  1);
        chk("fwd_data2", fwd_data, 32'hB);
        fwd_addr = 5'd6;
        #1;
        chk("fwd_miss", fwd_hit, 0);
        fwd_addr     = 5'd7;
        wb_reg_ready = 1'b1;
        step();
        chk("fwd_hit1",  fwd_hit,  1);
        chk("fwd_data1", fwd_data, 32'hB);
        step();
        chk("fwd_hit0",  fwd_hit,  0);
        chk("fwd_data0", fwd_data, 0);

        // r0 and writereg=0 beats are consumed without enqueueing
        push(5'd0, 32'hDEAD);
        #1;
        chk("r0_ready", mem_wb_ready, 1);
        step();
        push(5'd5, 32'hBEEF);
        mem_wb_writereg = 1'b0;
        #1;
        chk("nowr_ready", mem_wb_ready, 1);
        step();
        mem_wb_valid = 1'b0;
        chk("drop_count", wb_count, 0);
        chk("drop_en",    wb_reg_en, 0);
        fwd_addr = 5'd0;
        #1;
        chk("fwd_r0", fwd_hit, 0);

        // Asynchronous reset with three entries pending
        wb_reg_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(5'd12, 32'h700 + 32'(k));
            step();
        end
        mem_wb_valid = 1'b0;
        fwd_addr     = 5'd12;
        #1;
        chk("ar_count3", wb_count, 3);
        chk("ar_hit_pre", fwd_hit, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_count", wb_count, 0);
        chk("ar_en",    wb_reg_en, 0);
        chk("ar_hit",   fwd_hit,   0);
        #2;
        reset_n = 1'b1;
        wb_reg_ready = 1'b1;
        step();
        chk("ar_ready", mem_wb_ready, 1);
        chk("ar_stale", wb_reg_en,    0);
        step();
        chk("ar_stale2", wb_count, 0);

        // Randomized traffic against the queue model
        idle_inputs();
        do_reset();
        mq.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            mem_wb_valid    = ($urandom_range(0, 3) != 0);
            mem_wb_regdest  = AW'($urandom_range(0, 7));
            mem_wb_writereg = ($urandom_range(0, 7) != 0);
            mem_wb_memtoreg = $urandom_range(0, 1);
            mem_wb_loadtype = 3'($urandom_range(0, 7));
            mem_wb_byteaddr = 2'($urandom_range(0, 3));
            mem_wb_wbvalue  = $urandom;
            wb_reg_ready    = ($urandom_range(0, 2) == 0);
            fwd_addr        = AW'($urandom_range(0, 7));
            #1;
            e_ready = (mq.size() < DP);
            e_en    = (mq.size() != 0);
            e_addr  = e_en ? mq[0].a : '0;
            e_data  = e_en ? mq[0].d : '0;
            e_hit   = 1'b0;
            e_fdata = '0;
            for (int q = mq.size() - 1; q >= 0; q--) begin
                if (!e_hit && fwd_addr != 0 && mq[q].a == fwd_addr) begin
                    e_hit   = 1'b1;
                    e_fdata = mq[q].d;
                end
            end
            chk("rnd_ready", mem_wb_ready, e_ready);
            chk("rnd_en",    wb_reg_en,    e_en);
            chk("rnd_addr",  wb_reg_addr,  e_addr);
            chk("rnd_data",  wb_reg_data,  e_data);
            chk("rnd_count", wb_count,     mq.size());
            chk("rnd_hit",   fwd_hit,      e_hit);
            chk("rnd_fdata", fwd_data,     e_fdata);
            @(posedge clock);
            if (e_en && wb_reg_ready) void'(mq.pop_front());
            if (mem_wb_valid && e_ready && mem_wb_writereg && mem_wb_regdest != 0)
                mq.push_back('{mem_wb_regdest,
                               mfmt(mem_wb_memtoreg, mem_wb_loadtype,
                                    mem_wb_byteaddr, mem_wb_wbvalue)});
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
